// File: rtl/dmem_responder.sv
//------------------------------------------------------------------------------
// dmem_responder
// Memory-side end of the load/store interface. Accepts one request at a time,
// waits LATENCY cycles, then returns a response with lane-selected and
// sign/zero-extended load data.
// Build option: define DMEM_RESPONDER_ERR_EN to flag misaligned, out-of-range
// and illegal-size accesses on resp_err. Without it, accesses are
// force-aligned, size 3 acts as word and addresses wrap within the storage.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNTW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CNTW-1:0] LAT_CNT = CNTW'(LATENCY);
`ifdef DMEM_RESPONDER_ERR_EN
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              we_q, uns_q;
  logic [1:0]        size_q;
  logic [31:0]       addr_q, wdata_q;
  logic [31:0]       mem_q [DEPTH_WORDS];

  // Operands of the access: with zero latency the access happens on the
  // acceptance edge itself, so the live request fields are used in IDLE.
  logic              a_we, a_uns;
  logic [1:0]        a_size;
  logic [31:0]       a_addr, a_wdata;
  assign a_we    = (state_q == IDLE) ? req_we       : we_q;
  assign a_uns   = (state_q == IDLE) ? req_unsigned : uns_q;
  assign a_size  = (state_q == IDLE) ? req_size     : size_q;
  assign a_addr  = (state_q == IDLE) ? req_addr     : addr_q;
  assign a_wdata = (state_q == IDLE) ? req_wdata    : wdata_q;

  logic              acc_fire, acc_err, mem_wr;
  logic [1:0]        eff_size;
  logic [IDXW-1:0]   acc_idx;
  logic [3:0]        acc_be;
  logic [31:0]       acc_wword, acc_word, acc_rdata;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;

  assign acc_fire = ((state_q == WAIT) && (cnt_q == CNTW'(1))) ||
                    ((LATENCY == 0) && (state_q == IDLE) && req_valid);
  // The reset term keeps a store from committing while reset is held.
  assign mem_wr   = acc_fire && a_we && !acc_err && rst;

  // Decode size/alignment/range, build write lanes and the extended load value.
  always_comb begin
    eff_size = a_size;
    acc_err  = 1'b0;
`ifdef DMEM_RESPONDER_ERR_EN
    acc_err  = (a_size == 2'd3) ||
               ((a_size == 2'd1) && a_addr[0]) ||
               ((a_size == 2'd2) && (a_addr[1:0] != 2'b00)) ||
               ({1'b0, a_addr} >= ADDR_LIMIT);
    acc_idx  = IDXW'(a_addr >> 2);
`else
    if (a_size == 2'd3) eff_size = 2'd2;
    acc_idx  = IDXW'((a_addr >> 2) % 32'(DEPTH_WORDS));
`endif
    acc_word = mem_q[acc_idx];
    lane_b   = acc_word[{a_addr[1:0], 3'b000} +: 8];
    lane_h   = acc_word[{a_addr[1], 4'b0000} +: 16];
    case (eff_size)
      2'd0: begin
        acc_be    = 4'b0001 << a_addr[1:0];
        acc_wword = {4{a_wdata[7:0]}};
        acc_rdata = a_uns ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      2'd1: begin
        acc_be    = a_addr[1] ? 4'b1100 : 4'b0011;
        acc_wword = {2{a_wdata[15:0]}};
        acc_rdata = a_uns ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      end
      default: begin
        acc_be    = 4'b1111;
        acc_wword = a_wdata;
        acc_rdata = acc_word;
      end
    endcase
    if (acc_err || a_we) acc_rdata = '0;
  end

  // Byte-lane storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int l = 0; l < 4; l++) begin
        if (acc_be[l]) mem_q[acc_idx][8*l +: 8] <= acc_wword[8*l +: 8];
      end
    end
  end

  // State, countdown, latched request and held response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if ((state_q == IDLE) && req_valid) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cnt_d = LAT_CNT;
          if (LATENCY == 0) begin
            state_d = RESP;
            rdata_d = acc_rdata;
            err_d   = acc_err;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_d = RESP;
          rdata_d = acc_rdata;
          err_d   = acc_err;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
//------------------------------------------------------------------------------
// tb_dmem_responder
// Two responders (LATENCY=2 and LATENCY=0) checked every cycle against a
// transaction-level model with a byte-array memory, plus literal scenarios.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_responder;

  localparam int DEP  = 64;
  localparam int LAT0 = 2;
  localparam int LAT1 = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        rq_valid [2];
  logic        rq_ready [2];
  logic        rq_we    [2];
  logic        rq_uns   [2];
  logic [1:0]  rq_size  [2];
  logic [31:0] rq_addr  [2];
  logic [31:0] rq_wdata [2];
  logic        rs_valid [2];
  logic        rs_ready [2];
  logic        rs_err   [2];
  logic [31:0] rs_rdata [2];

  dmem_responder #(.DEPTH_WORDS(DEP), .LATENCY(LAT0)) u_dut0 (
    .clk(clk), .rst(rst_n), .req_valid(rq_valid[0]), .req_ready(rq_ready[0]),
    .req_we(rq_we[0]), .req_size(rq_size[0]), .req_unsigned(rq_uns[0]),
    .req_addr(rq_addr[0]), .req_wdata(rq_wdata[0]), .resp_valid(rs_valid[0]),
    .resp_ready(rs_ready[0]), .resp_rdata(rs_rdata[0]), .resp_err(rs_err[0]));

  dmem_responder #(.DEPTH_WORDS(DEP), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst(rst_n), .req_valid(rq_valid[1]), .req_ready(rq_ready[1]),
    .req_we(rq_we[1]), .req_size(rq_size[1]), .req_unsigned(rq_uns[1]),
    .req_addr(rq_addr[1]), .req_wdata(rq_wdata[1]), .resp_valid(rs_valid[1]),
    .resp_ready(rs_ready[1]), .resp_rdata(rs_rdata[1]), .resp_err(rs_err[1]));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h", nm, d, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm, input int d);
    tests++;
    fails++;
    $display("FAIL %s dut%0d: no DUT response within the cycle budget", nm, d);
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [7:0]  mb [2][DEP*4];
  bit          pend [2];
  bit          done [2];
  int          due  [2];
  int          nedge = 0;
  bit          t_we [2], t_uns [2];
  logic [1:0]  t_size [2];
  logic [31:0] t_addr [2], t_wdata [2];
  logic [31:0] m_rd [2];
  bit          m_err [2];

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic void model_do(input int d);
    longint unsigned a;
    int nb;
    logic [31:0] v;
    bit e;
    a = longint'(t_addr[d]);
    e = 1'b0;
    v = '0;
`ifdef DMEM_RESPONDER_ERR_EN
    nb = 1 << t_size[d];
    if (t_size[d] == 2'd3 || (t_size[d] == 2'd1 && a % 2 != 0) ||
        (t_size[d] == 2'd2 && a % 4 != 0) || a >= DEP * 4)
      e = 1'b1;
`else
    nb = (t_size[d] == 2'd3) ? 4 : (1 << t_size[d]);
    a = a % (DEP * 4);
    a = a - (a % nb);
`endif
    if (!e) begin
      if (t_we[d]) begin
        for (int i = 0; i < nb; i++) mb[d][a + i] = t_wdata[d][8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) v = v | (32'(mb[d][a + i]) << (8 * i));
        if (nb < 4 && !t_uns[d] && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      end
    end
    m_rd[d]  = (e || t_we[d]) ? 32'd0 : v;
    m_err[d] = e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        pend[d] = 1'b0;
        done[d] = 1'b0;
      end
    end else begin
      nedge++;
      for (int d = 0; d < 2; d++) begin
        if (pend[d] && done[d]) begin
          if (rs_ready[d]) begin
            pend[d] = 1'b0;
            done[d] = 1'b0;
          end
        end else if (pend[d]) begin
          if (nedge == due[d]) begin
            model_do(d);
            done[d] = 1'b1;
          end
        end else if (rq_valid[d]) begin
          t_we[d] = rq_we[d]; t_uns[d] = rq_uns[d]; t_size[d] = rq_size[d];
          t_addr[d] = rq_addr[d]; t_wdata[d] = rq_wdata[d];
          pend[d] = 1'b1;
          due[d]  = nedge + lat_of(d);
          if (lat_of(d) == 0) begin
            model_do(d);
            done[d] = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        chk("req_ready", d, 32'(rq_ready[d]), 32'(!pend[d]));
        chk("resp_valid", d, 32'(rs_valid[d]), 32'(pend[d] && done[d]));
        if (pend[d] && done[d]) begin
          chk("resp_rdata", d, rs_rdata[d], m_rd[d]);
          chk("resp_err", d, 32'(rs_err[d]), 32'(m_err[d]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic txn(input int d, input bit we, input logic [1:0] sz, input bit un,
                     input logic [31:0] a, input logic [31:0] wd, input int stall,
                     output logic [31:0] rd, output logic er, output int lat);
    int k;
    rd = '0; er = 1'b0; lat = -1;
    @(negedge clk);
    rq_valid[d] = 1'b1; rq_we[d] = we; rq_size[d] = sz; rq_uns[d] = un;
    rq_addr[d] = a; rq_wdata[d] = wd;
    k = 0;
    while (rq_ready[d] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) begin timeout_fail("accept_timeout", d); rq_valid[d] = 1'b0; return; end
    @(negedge clk);
    rq_valid[d] = 1'b0; rq_we[d] = 1'($urandom); rq_size[d] = 2'($urandom);
    rq_uns[d] = 1'($urandom); rq_addr[d] = $urandom; rq_wdata[d] = $urandom;
    k = 0;
    while (rs_valid[d] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) begin timeout_fail("resp_timeout", d); return; end
    lat = k; rd = rs_rdata[d]; er = rs_err[d];
    for (int s = 0; s < stall; s++) begin
      rq_valid[d] = 1'b1;
      @(negedge clk);
    end
    rq_valid[d] = 1'b0;
    rs_ready[d] = 1'b1;
    @(negedge clk);
    rs_ready[d] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_req_ready"}, d, 32'(rq_ready[d]), 32'd1);
      chk({tag, "_resp_valid"}, d, 32'(rs_valid[d]), 32'd0);
      chk({tag, "_resp_rdata"}, d, rs_rdata[d], 32'd0);
      chk({tag, "_resp_err"}, d, 32'(rs_err[d]), 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = $urandom;
      1:       a = $urandom_range(DEP * 4, DEP * 4 + 15);
      default: a = $urandom_range(0, DEP * 4 - 1);
    endcase
    if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
    return a;
  endfunction

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rq_valid[d] = 1'b0; rq_we[d] = 1'b0; rq_uns[d] = 1'b0; rq_size[d] = 2'd0;
      rq_addr[d] = '0; rq_wdata[d] = '0; rs_ready[d] = 1'b0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Fill both memories so every later load has defined data.
    for (int w = 0; w < DEP; w++)
      for (int d = 0; d < 2; d++)
        txn(d, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 0, rd, er, lat);

    // Word store then load, LATENCY=2.
    txn(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
    chk("store_err", 0, 32'(er), 32'd0);
    chk("resp_latency_cycles", 0, 32'(lat + 1), 32'd3);
    txn(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, er, lat);
    chk("word_load", 0, rd, 32'hDEADBEEF);

    // Byte/half lanes.
    txn(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, 0, rd, er, lat);
    txn(0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h12345680, 0, rd, er, lat);
    txn(0, 1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 0, rd, er, lat);
    chk("byte_load_signed", 0, rd, 32'hFFFFFF80);
    txn(0, 1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 0, rd, er, lat);
    chk("byte_load_unsigned", 0, rd, 32'h00000080);
    txn(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, rd, er, lat);
    chk("word_after_byte", 0, rd, 32'h00008000);
    txn(0, 1'b0, 2'd1, 1'b0, 32'h20, 32'h0, 0, rd, er, lat);
    chk("half_load_signed", 0, rd, 32'hFFFF8000);

    // Backpressure: response held 5 cycles while a new request waits.
    txn(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, rd, er, lat);
    chk("backpressure_load", 0, rd, 32'hDEADBEEF);

    // LATENCY=0 single access and a 4-request stream.
    txn(1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h5A5A0101, 0, rd, er, lat);
    chk("resp_latency_cycles", 1, 32'(lat + 1), 32'd1);
    begin
      int acc, dn, edges, k;
      bit started, a_now, h_now;
      acc = 0; dn = 0; edges = 0; k = 0; started = 1'b0;
      @(negedge clk);
      rs_ready[1] = 1'b1; rq_valid[1] = 1'b1; rq_we[1] = 1'b1; rq_size[1] = 2'd2;
      rq_addr[1] = 32'h80; rq_wdata[1] = $urandom;
      while (dn < 4 && k < 100) begin
        a_now = rq_valid[1] && rq_ready[1];
        h_now = rs_valid[1] && rs_ready[1];
        if (a_now) begin started = 1'b1; acc++; end
        if (started) edges++;
        if (h_now) dn++;
        @(negedge clk);
        k++;
        if (a_now) begin
          if (acc == 4) rq_valid[1] = 1'b0;
          else begin rq_addr[1] = 32'(32'h80 + 4 * acc); rq_wdata[1] = $urandom; end
        end
      end
      rq_valid[1] = 1'b0; rs_ready[1] = 1'b0;
      if (dn < 4) timeout_fail("stream_timeout", 1);
      else chk("stream_cycles", 1, 32'(edges), 32'd8);
    end

    // Error handling (or force-alignment when errors are not reported).
    txn(0, 1'b1, 2'd2, 1'b0, 32'h00, 32'h11223344, 0, rd, er, lat);
    txn(0, 1'b0, 2'd2, 1'b0, 32'h02, 32'h0, 0, rd, er, lat);
`ifdef DMEM_RESPONDER_ERR_EN
    chk("misaligned_word_err", 0, 32'(er), 32'd1);
    chk("misaligned_word_rdata", 0, rd, 32'd0);
`else
    chk("aligned_word_err", 0, 32'(er), 32'd0);
    chk("aligned_word_rdata", 0, rd, 32'h11223344);
`endif
    txn(0, 1'b1, 2'd1, 1'b0, 32'h03, 32'h0000AAAA, 0, rd, er, lat);
    txn(0, 1'b0, 2'd2, 1'b0, 32'h00, 32'h0, 0, rd, er, lat);
`ifdef DMEM_RESPONDER_ERR_EN
    chk("word0_unchanged", 0, rd, 32'h11223344);
`else
    chk("word0_half_aligned", 0, rd, 32'hAAAA3344);
`endif

    // Reset during WAIT of a store: the store must not commit.
    txn(0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h0BADF00D, 0, rd, er, lat);
    @(negedge clk);
    rq_valid[0] = 1'b1; rq_we[0] = 1'b1; rq_size[0] = 2'd2; rq_addr[0] = 32'h40;
    rq_wdata[0] = 32'h12345678;
    @(negedge clk);
    rq_valid[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_in_wait");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    txn(0, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0, rd, er, lat);
    chk("store_dropped_by_reset", 0, rd, 32'h0BADF00D);

    // Reset while a load response is waiting.
    begin
      int k;
      @(negedge clk);
      rq_valid[0] = 1'b1; rq_we[0] = 1'b0; rq_size[0] = 2'd2; rq_addr[0] = 32'h10;
      @(negedge clk);
      rq_valid[0] = 1'b0;
      k = 0;
      while (rs_valid[0] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      if (k >= 50) timeout_fail("resp_timeout", 0);
      chk("held_rdata", 0, rs_rdata[0], 32'hDEADBEEF);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("reset_in_resp");
      @(negedge clk);
      rst_n = 1'b1;
    end

    // Randomized traffic on both responders.
    for (int i = 0; i < 150; i++) begin
      for (int d = 0; d < 2; d++) begin
        txn(d, 1'($urandom), 2'($urandom), 1'($urandom), rand_addr(), $urandom,
            $urandom_range(0, 3), rd, er, lat);
      end
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
